// File: rtl/axil_pkg.sv
// Shared AXI4-Lite types: response codes, responder FSM states, strobe width.
package axil_pkg;

  localparam int AXIL_DATA_WIDTH = 32;
  localparam int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } axil_resp_e;

  typedef enum logic [1:0] {
    IDLE,
    WR_RESP,
    RD_MEM,
    RD_RESP
  } axil_slv_state_e;

endpackage

// File: rtl/soft_ram_sp.sv
// Single-port RAM, synchronous read (1 cycle), per-byte write enables.
// Always ready; contents are neither reset nor initialised.
module soft_ram_sp #(
  parameter int DEPTH      = 1024,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          re_i,
  input  logic [DATA_WIDTH/8-1:0]       we_i,
  input  logic [$clog2(DEPTH)-1:0]      addr_i,
  input  logic [DATA_WIDTH-1:0]         wdata_i,
  output logic [DATA_WIDTH-1:0]         rdata_o
);

  localparam int STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < STRB_W; b++) begin
      if (we_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
    if (re_i) rdata_o <= mem[addr_i];
  end

endmodule

// File: rtl/axil_soft_ram_slave.sv
// AXI4-Lite responder backed by soft RAM, one transaction in flight, round-robin R/W.
// B valid 1 cycle after AW/W handshake, R valid 2 cycles after AR; all readies low outside IDLE.
module axil_soft_ram_slave
  import axil_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h1000_0000,
  parameter int                    DEPTH_WORDS = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [ADDR_WIDTH-1:0]      s_awaddr_i,
  input  logic                       s_awvalid_i,
  output logic                       s_awready_o,
  input  logic [DATA_WIDTH-1:0]      s_wdata_i,
  input  logic [AXIL_STRB_WIDTH-1:0] s_wstrb_i,
  input  logic                       s_wvalid_i,
  output logic                       s_wready_o,
  output logic [1:0]                 s_bresp_o,
  output logic                       s_bvalid_o,
  input  logic                       s_bready_i,
  input  logic [ADDR_WIDTH-1:0]      s_araddr_i,
  input  logic                       s_arvalid_i,
  output logic                       s_arready_o,
  output logic [DATA_WIDTH-1:0]      s_rdata_o,
  output logic [1:0]                 s_rresp_o,
  output logic                       s_rvalid_o,
  input  logic                       s_rready_i
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  // The subtraction cannot wrap once addr >= BASE_ADDR, so only the offset's upper bits matter.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && (off[ADDR_WIDTH-1:IDX_W+2] == '0);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return off[IDX_W+1:2];
  endfunction

  axil_slv_state_e           state;
  logic                      last_was_write;
  logic                      rd_ok;
  logic                      idle;
  logic                      wr_pend;
  logic                      rd_pend;
  logic                      grant_wr;
  logic                      grant_rd;
  logic                      aw_ok;
  logic [IDX_W-1:0]          ram_addr;
  logic [AXIL_STRB_WIDTH-1:0] ram_we;
  logic [DATA_WIDTH-1:0]     ram_rdata;

  assign idle    = (state == IDLE) && !rst_i;
  assign wr_pend = s_awvalid_i && s_wvalid_i;
  assign rd_pend = s_arvalid_i;

  // On a tie the kind not served last wins.
  assign grant_wr = idle && wr_pend && (!rd_pend || !last_was_write);
  assign grant_rd = idle && rd_pend && (!wr_pend || last_was_write);

  assign s_awready_o = grant_wr;
  assign s_wready_o  = grant_wr;
  assign s_arready_o = grant_rd;

  assign aw_ok    = addr_ok(s_awaddr_i);
  assign ram_addr = grant_wr ? word_idx(s_awaddr_i) : word_idx(s_araddr_i);
  assign ram_we   = (grant_wr && aw_ok) ? s_wstrb_i : '0;

  soft_ram_sp #(
    .DEPTH      (DEPTH_WORDS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk_i   (clk_i),
    .re_i    (grant_rd),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (s_wdata_i),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      last_was_write <= 1'b0;
      rd_ok          <= 1'b0;
      s_bresp_o      <= OKAY;
      s_bvalid_o     <= 1'b0;
      s_rdata_o      <= '0;
      s_rresp_o      <= OKAY;
      s_rvalid_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_wr) begin
            s_bresp_o      <= aw_ok ? OKAY : SLVERR;
            s_bvalid_o     <= 1'b1;
            last_was_write <= 1'b1;
            state          <= WR_RESP;
          end else if (grant_rd) begin
            rd_ok          <= addr_ok(s_araddr_i);
            last_was_write <= 1'b0;
            state          <= RD_MEM;
          end
        end
        WR_RESP: begin
          if (s_bready_i) begin
            s_bvalid_o <= 1'b0;
            state      <= IDLE;
          end
        end
        RD_MEM: begin
          // RAM output is valid this cycle; out-of-range reads return zero.
          s_rdata_o  <= rd_ok ? ram_rdata : '0;
          s_rresp_o  <= rd_ok ? OKAY : SLVERR;
          s_rvalid_o <= 1'b1;
          state      <= RD_RESP;
        end
        RD_RESP: begin
          if (s_rready_i) begin
            s_rvalid_o <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_soft_ram_slave.sv
// Directed plus randomized bench for axil_soft_ram_slave against a word-array memory model.
module tb_axil_soft_ram_slave;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] mdl [DEPTH];

  always #5 clk = ~clk;

  axil_soft_ram_slave dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .s_awaddr_i  (awaddr),
    .s_awvalid_i (awvalid),
    .s_awready_o (awready),
    .s_wdata_i   (wdata),
    .s_wstrb_i   (wstrb),
    .s_wvalid_i  (wvalid),
    .s_wready_o  (wready),
    .s_bresp_o   (bresp),
    .s_bvalid_o  (bvalid),
    .s_bready_i  (bready),
    .s_araddr_i  (araddr),
    .s_arvalid_i (arvalid),
    .s_arready_o (arready),
    .s_rdata_o   (rdata),
    .s_rresp_o   (rresp),
    .s_rvalid_o  (rvalid),
    .s_rready_i  (rready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    longint la;
    la = longint'(a);
    return (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * DEPTH);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    return in_rng(a) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    return in_rng(a) ? mdl[widx(a)] : 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (in_rng(a)) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) mdl[widx(a)][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  // Leaves the caller at the start of cycle N+1, where N is the handshake cycle.
  task automatic issue_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit seen;
    seen = 1'b0;
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (awready && wready) begin seen = 1'b1; break; end
    end
    check("wr_handshake", 32'(seen), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    model_write(a, d, s);
  endtask

  task automatic issue_rd(input logic [31:0] a);
    bit seen;
    seen = 1'b0;
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (arready) begin seen = 1'b1; break; end
    end
    check("rd_handshake", 32'(seen), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic wr_chk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bready = 1'b1;
    issue_wr(a, d, s);
    @(negedge clk);
    check("bvalid_at_n1", 32'(bvalid), 32'd1);
    check("bresp", 32'(bresp), 32'(exp_resp(a)));
    @(posedge clk); #1;
  endtask

  task automatic rd_chk(input logic [31:0] a, output logic [31:0] d);
    rready = 1'b1;
    issue_rd(a);
    @(negedge clk);
    check("rvalid_low_at_n1", 32'(rvalid), 32'd0);
    @(negedge clk);
    check("rvalid_at_n2", 32'(rvalid), 32'd1);
    check("rresp", 32'(rresp), 32'(exp_resp(a)));
    check("rdata", rdata, exp_rdata(a));
    d = rdata;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] a;
    int          kinds[$];
    int          cycs[$];
    int          nw, nr;
    int          exp_kind[4];
    int          exp_cyc[4];

    rst = 1'b1;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    #12;
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_bresp", 32'(bresp), 32'd0);
    check("rst_rresp", 32'(rresp), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_readies", {29'd0, awready, wready, arready}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Basic write/read
    wr_chk(32'h1000_0010, 32'hDEAD_BEEF, 4'hF);
    rd_chk(32'h1000_0010, d);
    check("basic_rdata", d, 32'hDEAD_BEEF);

    // Partial strobes
    wr_chk(32'h1000_0010, 32'h1122_3344, 4'hF);
    wr_chk(32'h1000_0010, 32'hAABB_CCDD, 4'h5);
    rd_chk(32'h1000_0010, d);
    check("strobe_merge", d, 32'h11BB_33DD);
    wr_chk(32'h1000_0014, 32'h5555_5555, 4'h0);

    // Out of range and the range edges
    wr_chk(32'h1000_0000, 32'hCAFE_F00D, 4'hF);
    wr_chk(32'h1000_0FFC, 32'h0BAD_CAFE, 4'hF);
    wr_chk(32'h1000_1000, 32'hFFFF_FFFF, 4'hF);
    rd_chk(32'h0FFF_FFFC, d);
    rd_chk(32'h1000_1000, d);
    rd_chk(32'h1000_0000, d);
    check("oor_no_alias", d, 32'hCAFE_F00D);
    rd_chk(32'h1000_0FFF, d);

    // Split channels: AW alone must wait for W
    bready = 1'b1;
    @(posedge clk); #1;
    awaddr = 32'h1000_0020; wdata = 32'h0102_0304; wstrb = 4'hF; awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("aw_alone_no_ready", {30'd0, awready, wready}, 32'd0);
      @(posedge clk); #1;
    end
    wvalid = 1'b1;
    @(negedge clk);
    check("aw_w_ready", {30'd0, awready, wready}, 32'd3);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    model_write(32'h1000_0020, 32'h0102_0304, 4'hF);
    @(negedge clk);
    check("split_bvalid", 32'(bvalid), 32'd1);
    @(posedge clk); #1;
    rd_chk(32'h1000_0020, d);

    // Write backpressure with a competing read held off
    bready = 1'b0;
    issue_wr(32'h1000_1004, 32'h7777_7777, 4'hF);
    araddr = 32'h1000_0000; arvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_bvalid", 32'(bvalid), 32'd1);
      check("bp_bresp", 32'(bresp), 32'd2);
      check("bp_wr_readies", {29'd0, awready, wready, arready}, 32'd0);
      @(posedge clk); #1;
    end
    bready = 1'b1; arvalid = 1'b0;
    @(negedge clk);
    check("bp_bvalid_release", 32'(bvalid), 32'd1);
    @(negedge clk);
    check("bp_bvalid_done", 32'(bvalid), 32'd0);

    // Read backpressure with a competing write held off
    rready = 1'b0;
    issue_rd(32'h1000_0010);
    awaddr = 32'h1000_0010; wdata = 32'h0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_rvalid", 32'(rvalid), 32'd1);
      check("bp_rdata", rdata, 32'h11BB_33DD);
      check("bp_rresp", 32'(rresp), 32'd0);
      check("bp_rd_readies", {29'd0, awready, wready, arready}, 32'd0);
      @(posedge clk); #1;
    end
    rready = 1'b1; awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("bp_rvalid_done", 32'(rvalid), 32'd0);

    // Asynchronous reset while a read response is pending
    rready = 1'b0;
    issue_rd(32'h1000_0000);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_rvalid", 32'(rvalid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_rvalid", 32'(rvalid), 32'd0);
    check("async_rst_rdata", rdata, 32'd0);
    #3 rst = 1'b0;
    rready = 1'b1;

    // Tie arbitration right after reset: write, read, write, read
    bready = 1'b1; rready = 1'b1;
    nw = 0; nr = 0;
    exp_kind = '{1, 0, 1, 0};
    exp_cyc  = '{0, 2, 5, 7};
    @(posedge clk); #1;
    awaddr = 32'h1000_0030; wdata = 32'h3030_3030; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h1000_0000; arvalid = 1'b1;
    model_write(32'h1000_0030, 32'h3030_3030, 4'hF);
    for (int c = 0; c < 40 && (nw < 2 || nr < 2); c++) begin
      @(negedge clk);
      if (awready && wready) begin kinds.push_back(1); cycs.push_back(c); nw++; end
      if (arready) begin kinds.push_back(0); cycs.push_back(c); nr++; end
      @(posedge clk); #1;
      if (nw == 2) begin awvalid = 1'b0; wvalid = 1'b0; end
      if (nr == 2) arvalid = 1'b0;
    end
    check("arb_grants", 32'(kinds.size()), 32'd4);
    for (int i = 0; i < 4 && i < kinds.size(); i++) begin
      check("arb_kind", 32'(kinds[i]), 32'(exp_kind[i]));
      check("arb_cycle", 32'(cycs[i]), 32'(exp_cyc[i]));
    end
    repeat (4) @(posedge clk);
    #1;
    rd_chk(32'h1000_0030, d);
    rd_chk(32'h1000_0000, d);

    // Randomized traffic over a prewritten window plus out-of-range addresses
    for (int i = 0; i < 16; i++) wr_chk(BASE + 32'(i * 4), $urandom, 4'hF);
    for (int i = 0; i < 48; i++) begin
      case ($urandom_range(0, 3))
        0, 1, 2: a = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
        default: a = $urandom_range(0, 1) ? BASE + 32'h1000 + 32'($urandom_range(0, 255))
                                          : BASE - 32'd1 - 32'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 1) == 1) wr_chk(a, $urandom, 4'($urandom_range(0, 15)));
      else rd_chk(a, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axil_soft_ram_slave.md
# axil_soft_ram_slave

AXI4-Lite responder that serves single-beat reads and writes from an on-chip soft RAM. It is the subordinate end of the SoC AXI4-Lite fabric and pairs with the core-side AXI4-Lite initiator. It is the memory target instantiated when `USE_SOFT_MEMORY_MODULES = 1`. At most one transaction is in flight at a time, and pending reads and writes are arbitrated round-robin.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: AXI4-Lite address width; equals `AXI4L_CONF_ADDR_WIDTH`.
- `DATA_WIDTH`, default 32: data width; only 32 is supported.
- `BASE_ADDR`, default 32'h1000_0000: first byte address served.
- `DEPTH_WORDS`, default 1024: RAM depth in 32-bit words; must be a power of two.

Ports:
- `clk_i`, in, 1: clock, rising edge.
- `rst_i`, in, 1: asynchronous, active-high reset.
- `s_awaddr_i`, in, ADDR_WIDTH; `s_awvalid_i`, in, 1; `s_awready_o`, out, 1: write address channel.
- `s_wdata_i`, in, 32; `s_wstrb_i`, in, 4; `s_wvalid_i`, in, 1; `s_wready_o`, out, 1: write data channel.
- `s_bresp_o`, out, 2; `s_bvalid_o`, out, 1; `s_bready_i`, in, 1: write response channel.
- `s_araddr_i`, in, ADDR_WIDTH; `s_arvalid_i`, in, 1; `s_arready_o`, out, 1: read address channel.
- `s_rdata_o`, out, 32; `s_rresp_o`, out, 2; `s_rvalid_o`, out, 1; `s_rready_i`, in, 1: read data channel.

## Operation
States: `IDLE`, `WR_RESP`, `RD_MEM`, `RD_RESP`.

- **IDLE, write pending:** a write is pending when both `s_awvalid_i` and `s_wvalid_i` are high.
  - `s_awready_o` and `s_wready_o` assert together, in the same cycle, only when the write is granted.
  - An AW without W, or a W without AW, is never accepted alone.
- **IDLE, read pending:** a read is pending when `s_arvalid_i` is high. `s_arready_o` asserts only when the read is granted.
- **Arbitration:** if only one kind of transaction is pending, it wins. If both are pending, the kind not served last wins. The `last_was_write` flag resets to 0, so writes win the first tie.
- **Write handshake cycle:**
  - The RAM is written with a per-byte enable of `s_wstrb_i`.
  - `bresp` is latched, then go to `WR_RESP`.
  - In `WR_RESP`, `s_bvalid_o` is held high until `s_bready_i`, then return to `IDLE`.
- **Read handshake cycle:**
  - The RAM read is issued, then go to `RD_MEM`.
  - `RD_MEM` lasts one cycle: the RAM output is captured into `s_rdata_o`, then go to `RD_RESP`.
  - In `RD_RESP`, `s_rvalid_o` is held high until `s_rready_i`, then return to `IDLE`.
- **Address decode:**
  - Word index = (addr − BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
  - addr[1:0] is ignored.
  - An address outside [BASE_ADDR, BASE_ADDR + 4·DEPTH_WORDS) is out of range. It gets SLVERR (2'b10): no RAM write, and `s_rdata_o` = 0.
  - In-range accesses get OKAY (2'b00).
- **Write strobes:** `s_wstrb_i` = 0 is a legal no-op write that still returns OKAY.
- **RAM contents:** not reset and not initialised; reading before writing returns X in simulation.

## Timing
- **Write latency:** AW/W handshake in cycle N → `s_bvalid_o` high in N+1.
- **Read latency:** AR handshake in cycle N → `s_rvalid_o` high in N+2.
- **Back-to-back throughput:** with ready held high, one write every 2 cycles and one read every 3 cycles.
- **Outstanding transactions:** none new. All `*ready_o` outputs are low outside `IDLE`.
- **Output stability:** `s_bresp_o`, `s_rdata_o` and `s_rresp_o` are stable while the corresponding valid is high.
- **Combinational paths:**
  - Valid inputs may reach the ready outputs combinationally.
  - `s_bready_i` and `s_rready_i` only affect state.
- **Reset values:** all outputs are 0, state = `IDLE`, `last_was_write` = 0.
- **Reset mid-operation:**
  - A pending response is dropped.
  - A RAM write already performed in a handshake cycle is kept.
- **Ignored inputs:** a valid input that drops before its handshake is simply never accepted; no protocol check is made.

## Structure
- Shared package `axil_pkg`:
  - `axil_resp_e` with OKAY = 2'b00 and SLVERR = 2'b10.
  - `axil_slv_state_e` for the four states.
  - The strobe width localparam, DATA_WIDTH/8.
- Sub-module `soft_ram_sp`:
  - Single-port RAM, synchronous read, per-byte write enables.
  - Parameters DEPTH and DATA_WIDTH.
  - Reusable by the ROM and BRAM variants.
- The FSM, arbiter and decode live in the top module.

## Test plan
1. **Basic write/read:**
   - Stimulus: write 0xDEADBEEF to 0x1000_0010 with strobe 0xF, then read 0x1000_0010.
   - Required: `bvalid` at N+1 with OKAY; `rdata` = 0xDEADBEEF with OKAY, `rvalid` at N+2.
2. **Partial strobes:**
   - Stimulus: write 0x11223344 with strobe 0xF, then 0xAABBCCDD with strobe 0x5 to the same word, then read it.
   - Required: read returns 0x11BB33DD.
3. **Out of range:**
   - Stimulus: write to 0x1000_1000 with DEPTH_WORDS = 1024, then read 0x0FFF_FFFC.
   - Required: both return SLVERR, `rdata` = 0, and the word at 0x1000_0000 is unchanged.
4. **Arbitration and split channels:**
   - Stimulus: hold AW/W and AR valid from the same cycle, for two transactions each.
   - Required: grant order is write, read, write, read.
   - Stimulus: AW alone for 5 cycles before W.
   - Required: no `awready` until W arrives.
5. **Backpressure:**
   - Stimulus: hold `bready` and `rready` low for 10 cycles.
   - Required: `bvalid`/`rvalid` and the data stay stable, and all `*ready_o` stay low the whole time.
6. **Reset mid-response:**
   - Stimulus: assert `rst_i` asynchronously while in `RD_RESP`.
   - Required: `rvalid` drops immediately, state is `IDLE`, and a following transaction completes normally.
